// File: rtl/sipo_word_loader_if.sv
// -----------------------------------------------------------------------------
// sipo_word_loader_if
//
// Bundles the serial input side and the parallel output side of
// sipo_word_loader into one interface.
//
// Handshake: there is no back-pressure. A serial bit is transferred on every
// rising clk edge where sin_valid=1. sin_first tags that bit as the start of
// a word and is ignored when sin_valid=0. On the output side, load is a
// one-cycle strobe meaning "pdata now holds a freshly completed word". The
// consumer must capture pdata in that cycle, or at any later time before the
// next load, because pdata holds its value between words.
//
// Signals:
//   sin        serial data bit                       (master -> slave)
//   sin_valid  sin carries a real bit this cycle     (master -> slave)
//   sin_first  bit is the first of a word            (master -> slave)
//   pdata      last completed word, WIDTH bits       (slave -> master)
//   load       one-cycle pulse when pdata updates    (slave -> master)
//   busy       a word is partially assembled         (slave -> master)
//   frame_err  one-cycle pulse, partial word dropped (slave -> master)
//   dbg_state  FSM state, 0=IDLE 1=SHIFT             (slave -> master)
//   dbg_cnt    bits accepted into the current word   (slave -> master)
//
// Modports:
//   slave   the word loader itself
//   master  the serial source and the word consumer (e.g. a testbench)
// -----------------------------------------------------------------------------
interface sipo_word_loader_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             sin;
   logic             sin_valid;
   logic             sin_first;
   logic [WIDTH-1:0] pdata;
   logic             load;
   logic             busy;
   logic             frame_err;
   logic             dbg_state;
   logic [CW-1:0]    dbg_cnt;

   modport slave (
      input  sin, sin_valid, sin_first,
      output pdata, load, busy, frame_err, dbg_state, dbg_cnt
   );

   modport master (
      output sin, sin_valid, sin_first,
      input  pdata, load, busy, frame_err, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/sipo_word_loader.sv
// -----------------------------------------------------------------------------
// sipo_word_loader
//
// Serial-to-parallel word assembler. It collects a framed serial bit stream
// into a WIDTH-bit word. Each completed word is presented on a stable
// parallel bus with a one-cycle load strobe, so a downstream PIPO register
// can be fed from a single serial line.
//
// Parameters:
//   WIDTH      word width in bits, 2..32
//   LSB_FIRST  1: first serial bit lands in pdata[0]
//              0: first serial bit lands in pdata[WIDTH-1]
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   sipo_word_loader_if.slave (serial in, parallel out, status, debug)
//
// Every output comes straight from a flop. There is no combinational path
// from inputs to outputs.
// -----------------------------------------------------------------------------
module sipo_word_loader #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   sipo_word_loader_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;
   logic [WIDTH-1:0] pdata_q, pdata_d;
   logic             load_q,  load_d;
   logic             ferr_q,  ferr_d;

   // Shifts one bit into the word. In LSB-first mode, bits enter at the top
   // and move down, so after WIDTH shifts the first bit sits at bit 0. In
   // MSB-first mode, bits enter at the bottom and move up, so the first bit
   // ends at WIDTH-1.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                 input logic             b);
      if (LSB_FIRST)
         return {b, base[WIDTH-1:1]};
      else
         return {base[WIDTH-2:0], b};
   endfunction

   // A new word always starts from an all-zero register, so nothing from an
   // abandoned word can leak into the next one.
   logic [WIDTH-1:0] start_word;
   logic [WIDTH-1:0] next_word;
   logic             last_bit;

   always_comb begin
      start_word = shift_in('0, bus.sin);
      next_word  = shift_in(sreg_q, bus.sin);
      // cnt_q counts bits already taken. The bit arriving now completes the
      // word when WIDTH-1 bits are already held.
      last_bit   = (cnt_q == CW'(WIDTH - 1));
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      pdata_d = pdata_q;
      load_d  = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Bits without sin_first are dropped silently here. They belong
            // to a word whose start was never seen.
            if (bus.sin_valid && bus.sin_first) begin
               sreg_d  = start_word;
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (bus.sin_valid) begin
               if (bus.sin_first) begin
                  // A fresh start mid-word abandons the partial word and
                  // reuses this bit as bit 0 of the new one.
                  ferr_d = 1'b1;
                  sreg_d = start_word;
                  cnt_d  = CW'(1);
               end else if (last_bit) begin
                  pdata_d = next_word;
                  load_d  = 1'b1;
                  sreg_d  = '0;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  sreg_d = next_word;
                  cnt_d  = cnt_q + CW'(1);
               end
            end
            // sin_valid=0: gaps of any length simply hold state.
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         pdata_q <= '0;
         load_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         pdata_q <= pdata_d;
         load_q  <= load_d;
         ferr_q  <= ferr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.pdata     = pdata_q;
   assign bus.load      = load_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q == SHIFT);
   assign bus.dbg_state = state_q;
   assign bus.dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_sipo_word_loader.sv
module tb_sipo_word_loader;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_word_loader_if #(.WIDTH(W)) if_l ();
  sipo_word_loader_if #(.WIDTH(W)) if_m ();

  sipo_word_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (if_l)
  );

  sipo_word_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (if_m)
  );

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int loads_l = 0;
  int ferrs_l = 0;
  int last_load_cyc = 0;

  // ---------------- reference model ----------------
  // Words are modelled as a queue of received bits. Placement is applied
  // only when a word completes.
  logic bits_q[$];
  bit in_word = 1'b0;
  logic [W-1:0] pd_l, pd_m;
  bit e_load, e_ferr;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic f, input logic s);
    e_load = 1'b0;
    e_ferr = 1'b0;
    if (r) begin
      bits_q.delete();
      in_word = 1'b0;
      pd_l = '0;
      pd_m = '0;
    end else if (v) begin
      if (f) begin
        if (in_word) e_ferr = 1'b1;
        bits_q.delete();
        bits_q.push_back(s);
        in_word = 1'b1;
      end else if (in_word) begin
        bits_q.push_back(s);
        if (bits_q.size() == W) begin
          for (int k = 0; k < W; k++) begin
            pd_l[k] = bits_q[k];
            pd_m[W-1-k] = bits_q[k];
          end
          e_load = 1'b1;
          exp_q.push_back(pd_l);
          bits_q.delete();
          in_word = 1'b0;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic f, input logic s);
    rst = r;
    if_l.sin_valid = v; if_l.sin_first = f; if_l.sin = s;
    if_m.sin_valid = v; if_m.sin_first = f; if_m.sin = s;
    @(posedge clk);
    model(r, v, f, s);
    cyc++;
    @(negedge clk);
    chk("load_l", if_l.load, e_load);
    chk("load_m", if_m.load, e_load);
    chk("ferr_l", if_l.frame_err, e_ferr);
    chk("ferr_m", if_m.frame_err, e_ferr);
    chk("busy_l", if_l.busy, in_word);
    chk("busy_m", if_m.busy, in_word);
    chk("state_l", if_l.dbg_state, in_word);
    chk("cnt_l", if_l.dbg_cnt, bits_q.size());
    chk("cnt_m", if_m.dbg_cnt, bits_q.size());
    chk("pdata_l", if_l.pdata, pd_l);
    chk("pdata_m", if_m.pdata, pd_m);
    chk("excl_l", if_l.load & if_l.frame_err, 0);
    if (if_l.frame_err === 1'b1) ferrs_l++;
    if (if_l.load === 1'b1) begin
      loads_l++;
      last_load_cyc = cyc;
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("sb_word", if_l.pdata, exp_q.pop_front());
    end
  endtask

  // Sends n bits, bits[0] first; gap idle cycles follow each bit.
  task automatic send(input int n, input logic [31:0] bits, input bit first, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, (first && i == 0), bits[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int l0, f0, c1;
    logic r, v, f, s;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_pdata", if_l.pdata, 0);
    chk("rst_busy", if_l.busy, 0);
    chk("rst_load", if_l.load, 0);
    chk("rst_ferr", if_l.frame_err, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // nominal word 1,0,0,1
    send(4, 32'b1001, 1'b1, 0);
    chk("nom_load", if_l.load, 1);
    chk("nom_pdata_l", if_l.pdata, 4'b1001);
    chk("nom_pdata_m", if_m.pdata, 4'b1001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("nom_load_drop", if_l.load, 0);

    // gapped word 1,1,0,1
    send(2, 32'b11, 1'b1, 3);
    chk("gap_hold_l", if_l.pdata, 4'b1001);
    chk("gap_hold_m", if_m.pdata, 4'b1001);
    send(2, 32'b10, 1'b0, 3);
    chk("gap_pdata_l", if_l.pdata, 4'b1011);
    chk("gap_pdata_m", if_m.pdata, 4'b1101);

    // framing error: 2 bits, then new word 0,1,1,0
    l0 = loads_l; f0 = ferrs_l;
    send(2, 32'b01, 1'b1, 0);
    send(4, 32'b0110, 1'b1, 0);
    chk("fe_count", ferrs_l - f0, 1);
    chk("fe_loads", loads_l - l0, 1);
    chk("fe_pdata_l", if_l.pdata, 4'b0110);
    chk("fe_pdata_m", if_m.pdata, 4'b0110);

    // idle junk
    step(1'b0, 1'b0, 1'b0, 1'b0);
    l0 = loads_l; f0 = ferrs_l;
    send(5, 32'b10110, 1'b0, 0);
    chk("junk_loads", loads_l - l0, 0);
    chk("junk_ferrs", ferrs_l - f0, 0);
    chk("junk_busy", if_l.busy, 0);
    chk("junk_pdata", if_l.pdata, 4'b0110);

    // reset mid-word
    send(3, 32'b101, 1'b1, 0);
    l0 = loads_l;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rmw_pdata", if_l.pdata, 0);
    chk("rmw_busy", if_l.busy, 0);
    chk("rmw_load", if_l.load, 0);
    send(4, 32'b1111, 1'b1, 0);
    chk("rmw_word", if_l.pdata, 4'b1111);
    chk("rmw_loads", loads_l - l0, 1);

    // back-to-back
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send(4, 32'b1001, 1'b1, 0);
    chk("b2b_first", if_l.pdata, 4'b1001);
    c1 = last_load_cyc;
    send(4, 32'b0110, 1'b1, 0);
    chk("b2b_spacing", last_load_cyc - c1, 4);
    chk("b2b_second", if_l.pdata, 4'b0110);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 1);
      step(r, v, f, s);
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sipo_word_loader.md
# sipo_word_loader

Serial-to-parallel word assembler that sits directly upstream of the team's PIPO register stage. It collects a framed serial bit stream into a WIDTH-bit word. It presents the word as a stable parallel bus with a one-cycle load strobe, so the PIPO's D input can be driven from a single serial line. It also reports framing errors and handles gaps in the bit stream.

## Interface
Parameters:
- WIDTH, default 4: word width in bits; legal range 2..32.
- LSB_FIRST, default 1: 1 = first serial bit lands in pdata[0]; 0 = first serial bit lands in pdata[WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is a real bit this cycle.
- sin_first  input  1  qualifies the bit as the first of a word; ignored when sin_valid=0.
- pdata  output  WIDTH  last completed word; feeds PIPO D.
- load  output  1  one-cycle pulse when pdata updates; drives the PIPO capture enable.
- busy  output  1  a word is partially assembled.
- frame_err  output  1  one-cycle pulse when a partial word is abandoned.

## Operation
- State machine has two states:
  - IDLE: no word in progress.
  - SHIFT: word in progress.
- Internal storage:
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, width $clog2(WIDTH+1), counting accepted bits of the current word.
- IDLE behaviour:
  - sin_valid=1 and sin_first=1: accept bit 0 of a new word, set cnt=1, go to SHIFT.
  - sin_valid=1 and sin_first=0: bit silently dropped, no error, stay in IDLE.
  - sin_valid=0: no change.
- SHIFT behaviour:
  - sin_valid=1 and sin_first=0: accept the bit, cnt+1.
  - If that bit is the WIDTH-th, the word completes: pdata <= assembled word, load=1, cnt=0, go to IDLE.
  - sin_valid=1 and sin_first=1: partial word discarded, frame_err=1. The same bit starts a new word (cnt=1), stay in SHIFT.
  - sin_valid=0: hold everything; gaps of any length are legal, with no timeout.
- Bit placement:
  - LSB_FIRST=1: k-th accepted bit (k=0..WIDTH-1) goes to word bit k.
  - LSB_FIRST=0: k-th accepted bit goes to word bit WIDTH-1-k.
- pdata changes only on word completion or reset; it holds between words.
- Bits of an incomplete word never appear on pdata.
- busy = (state == SHIFT).
- load and frame_err are never both 1 in the same cycle.

## Timing
- Reset values, applied on the first rising edge with rst=1:
  - pdata=0, load=0, busy=0, frame_err=0.
  - state=IDLE, cnt=0, sreg=0.
- rst=1 has priority over all inputs, including mid-word: the partial word is lost and no load or frame_err is raised.
- Latency: load and the new pdata are visible in the cycle after the edge that samples the last bit.
- With no gaps, a word takes WIDTH cycles plus 1 cycle of output latency.
- load is high for exactly one cycle per completed word.
- Back-to-back words: sin_first may arrive in the cycle immediately after the last bit of the previous word, which is the cycle load is high. The new word starts with no dead cycle, giving a throughput of one word per WIDTH cycles.
- frame_err asserts in the cycle after the offending sin_first is sampled.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Nominal word: WIDTH=4, LSB_FIRST=1, contiguous bits 1,0,0,1 with sin_first on the first bit.
  - Required: pdata=4'b1001 and load=1 for exactly one cycle, 1 cycle after the 4th bit.
  - Required: busy=1 for the 3 cycles between accepting the 1st and the 4th bit, then 0.
- Gaps and ordering:
  - Same bits 1,1,0,1 with sin_valid=0 for 3 cycles between every bit, LSB_FIRST=1. Required: pdata=4'b1011.
  - Same stream with LSB_FIRST=0. Required: pdata=4'b1101.
  - In both runs pdata holds its previous value until completion.
- Framing error:
  - Send 2 bits of a word, then sin_first with bits 0,1,1,0.
  - Required: frame_err pulses once, no load for the partial word, then pdata=4'b0110 with load.
- Idle junk: 5 valid bits with sin_first=0 while IDLE. Required: no load, no frame_err, busy=0, pdata unchanged.
- Reset mid-word: 3 bits accepted, then rst=1 for 1 cycle, then a full word 1,1,1,1.
  - Required: outputs all 0 after reset, no spurious load.
  - Required: then pdata=4'b1111 with a single load.
- Back-to-back: two words 1001 then 0110 with no idle cycle between them.
  - Required: two load pulses exactly 4 cycles apart.
  - Required: pdata 4'b1001 then 4'b0110.
